// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: round-robin multi-channel byte-serial memory
// sequencer with wait states, bus stall and optional page-wrap addressing.
module mem_access_sequencer #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int NCH    = 3,
  parameter int MAXLEN = 4,
  parameter int WAIT   = 0,
  localparam int LW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_x,
  input  logic                    i_rdy,
  input  logic [DW-1:0]           i_db,
  output logic [DW-1:0]           o_db,
  output logic [AW-1:0]           o_ab,
  output logic                    o_rw,
  input  logic [NCH-1:0]          req,
  input  logic [NCH-1:0]          req_we,
  input  logic [NCH-1:0]          req_wrap,
  input  logic [NCH*AW-1:0]       req_addr,
  input  logic [NCH*LW-1:0]       req_len,
  input  logic [NCH*MAXLEN*DW-1:0] req_wdata,
  output logic [NCH-1:0]          gnt,
  output logic [NCH-1:0]          done,
  output logic [MAXLEN*DW-1:0]    rdata,
  output logic                    busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [2:0] WRLD   = 3'(WAIT);

  logic [1:0]           state;
  logic [CW-1:0]        rr;
  logic [CW-1:0]        ch;
  logic [CW-1:0]        sel;
  logic                 hit;
  logic [LW-1:0]        len;
  logic [LW-1:0]        idx;
  logic                 we;
  logic                 wrap;
  logic [MAXLEN*DW-1:0] wdata;
  logic [AW-1:0]        ab;
  logic [AW-1:0]        ab_inc;
  logic [2:0]           wcnt;

  // first requester at or above rr, searching upward modulo NCH
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      int c;
      c = int'(rr) + i;
      if (c >= NCH) c = c - NCH;
      if (req[c]) begin
        sel = CW'(c);
        hit = 1'b1;
      end
    end
  end

  // page-wrap mode only advances the low byte
  always_comb begin
    ab_inc = ab + AW'(1);
    if (wrap) ab_inc = {ab[AW-1:8], ab[7:0] + 8'd1};
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state <= IDLE;
      rr    <= '0;
      ch    <= '0;
      len   <= '0;
      idx   <= '0;
      we    <= 1'b0;
      wrap  <= 1'b0;
      wdata <= '0;
      ab    <= '0;
      wcnt  <= '0;
      gnt   <= '0;
      rdata <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (hit) begin
            ch    <= sel;
            rr    <= (sel == CW'(NCH - 1)) ? '0 : sel + CW'(1);
            ab    <= req_addr[sel*AW +: AW];
            len   <= req_len[sel*LW +: LW];
            we    <= req_we[sel];
            wrap  <= req_wrap[sel];
            wdata <= req_wdata[sel*MAXLEN*DW +: MAXLEN*DW];
            idx   <= '0;
            wcnt  <= WRLD;
            rdata <= '0;
            gnt   <= NCH'(1) << sel;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
          end else if (i_rdy) begin
            if (!we) rdata[idx*DW +: DW] <= i_db;
            if (idx == len) begin
              state <= DONE;
            end else begin
              idx  <= idx + LW'(1);
              wcnt <= WRLD;
              ab   <= ab_inc;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ab = ab;
  assign busy = (state != IDLE);
  assign o_rw = (state == ACCESS) ? !we : 1'b1;
  assign o_db = (state == ACCESS && we) ? wdata[idx*DW +: DW] : '0;
  assign done = (state == DONE) ? (NCH'(1) << ch) : '0;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: transfer-level reference model,
// directed scenarios with literal traces, then randomized traffic.
module tb_mem_access_sequencer;
  localparam int AW = 16, DW = 8, NCH = 3, MAXLEN = 4, WAIT = 1, LW = 2;

  logic clk = 1'b0;
  logic rst_x;
  logic i_rdy = 1'b0;
  logic [7:0] i_db, o_db;
  logic [15:0] o_ab;
  logic o_rw, busy;
  logic [2:0] req = '0, req_we = '0, req_wrap = '0;
  logic [47:0] req_addr = '0;
  logic [5:0] req_len = '0;
  logic [95:0] req_wdata = '0;
  logic [2:0] gnt, done;
  logic [31:0] rdata;

  logic [7:0] mem [0:65535];
  assign i_db = mem[o_ab];

  always #5 clk = ~clk;

  mem_access_sequencer #(
    .AW(AW), .DW(DW), .NCH(NCH), .MAXLEN(MAXLEN), .WAIT(WAIT)
  ) dut (
    .clk(clk), .rst_x(rst_x), .i_rdy(i_rdy), .i_db(i_db),
    .o_db(o_db), .o_ab(o_ab), .o_rw(o_rw),
    .req(req), .req_we(req_we), .req_wrap(req_wrap),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit auto_drop = 1'b1;
  bit [2:0] pend = '0;

  // reference model: transfer progress as byte number and elapsed cycles
  int m_phase = 0, m_ch = 0, m_k = 0, m_el = 0, m_rr = 0, m_len = 0;
  logic [15:0] m_start = '0, m_ab = '0;
  bit m_we = 1'b0, m_wrap = 1'b0;
  logic [31:0] m_wd = '0, m_rdata = '0;

  logic [15:0] q_ab [$];
  logic [7:0] q_db [$];
  logic q_rw [$];
  logic [2:0] g_val [$];
  int g_cyc [$];
  logic [2:0] d_val [$];
  logic [31:0] d_rdata;

  function automatic logic [15:0] addr_at(logic [15:0] s, int k, bit w);
    logic [15:0] a;
    a = s + 16'(k);
    if (w) a = {s[15:8], a[7:0]};
    return a;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ch = 0; m_k = 0; m_el = 0; m_rr = 0; m_len = 0;
    m_ab = '0; m_rdata = '0; m_we = 1'b0;
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      if (req != 3'b0) begin
        int c;
        c = 0;
        for (int i = 0; i < NCH; i++) begin
          if (req[(m_rr + i) % NCH]) begin
            c = (m_rr + i) % NCH;
            break;
          end
        end
        m_ch = c;
        m_rr = (c + 1) % NCH;
        m_start = req_addr[c*16 +: 16];
        m_len = int'(req_len[c*2 +: 2]);
        m_we = req_we[c];
        m_wrap = req_wrap[c];
        m_wd = req_wdata[c*32 +: 32];
        m_k = 0; m_el = 0;
        m_ab = m_start;
        m_rdata = '0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_el >= WAIT && i_rdy) begin
        if (!m_we) m_rdata[m_k*8 +: 8] = mem[m_ab];
        if (m_k == m_len) m_phase = 2;
        else begin
          m_k++;
          m_el = 0;
          m_ab = addr_at(m_start, m_k, m_wrap);
        end
      end else m_el++;
    end else m_phase = 0;
  endtask

  function automatic bit first_cycle();
    return m_phase == 1 && m_k == 0 && m_el == 0;
  endfunction

  task automatic check_model();
    logic [2:0] eg, ed;
    eg = first_cycle() ? 3'(1 << m_ch) : 3'b0;
    ed = (m_phase == 2) ? 3'(1 << m_ch) : 3'b0;
    chk("gnt", gnt, eg);
    chk("done", done, ed);
    chk("busy", busy, m_phase != 0);
    chk("o_ab", o_ab, m_ab);
    chk("o_rw", o_rw, (m_phase == 1) ? !m_we : 1'b1);
    chk("o_db", o_db, (m_phase == 1 && m_we) ? m_wd[m_k*8 +: 8] : 8'h00);
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic clear_trace();
    q_ab.delete(); q_db.delete(); q_rw.delete();
    g_val.delete(); g_cyc.delete(); d_val.delete();
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    cyc++;
    check_model();
    if (busy && done == 3'b0) begin
      q_ab.push_back(o_ab); q_db.push_back(o_db); q_rw.push_back(o_rw);
    end
    if (gnt != 3'b0) begin g_val.push_back(gnt); g_cyc.push_back(cyc); end
    if (done != 3'b0) begin d_val.push_back(done); d_rdata = rdata; end
    if (first_cycle()) begin
      if (auto_drop) req[m_ch] = 1'b0;
      pend[m_ch] = 1'b0;
    end
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_o_ab"}, o_ab, 16'h0);
    chk({tag, "_o_db"}, o_db, 8'h0);
    chk({tag, "_o_rw"}, o_rw, 1'b1);
    chk({tag, "_gnt"}, gnt, 3'b0);
    chk({tag, "_done"}, done, 3'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rdata"}, rdata, 32'h0);
  endtask

  // called at posedge+1; reset lands mid-cycle
  task automatic do_reset_mid();
    #2 rst_x = 1'b0;
    #1 reset_checks("rst_mid");
    model_reset();
    req = '0; pend = '0;
    @(negedge clk);
    rst_x = 1'b1;
    step();
  endtask

  task automatic set_ch(int c, logic [15:0] a, int len, bit w, bit wr,
                        logic [31:0] wd);
    req_addr[c*16 +: 16] = a;
    req_len[c*2 +: 2] = 2'(len);
    req_we[c] = w;
    req_wrap[c] = wr;
    req_wdata[c*32 +: 32] = wd;
    req[c] = 1'b1;
    pend[c] = 1'b1;
  endtask

  task automatic run_done(string name, int bound, int stall);
    int n, left;
    n = 0;
    left = stall;
    while (d_val.size() == 0 && n < bound) begin
      if (m_phase == 1 && left > 0) begin i_rdy = 1'b0; left--; end
      else i_rdy = 1'b1;
      step();
      n++;
    end
    chk({name, "_timeout"}, d_val.size() != 0, 1'b1);
    step();
  endtask

  task automatic chk_trace(string name, logic [15:0] exp [$]);
    chk({name, "_len"}, q_ab.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q_ab.size(); i++)
      chk(name, q_ab[i], exp[i]);
  endtask

  task automatic drive_random();
    logic [15:0] a;
    i_rdy = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < NCH; c++) begin
      if (!pend[c] && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: a = 16'hFFFF - 16'($urandom_range(0, 3));
          1: a = {8'($urandom), 8'hFC | 8'($urandom_range(0, 3))};
          default: a = 16'($urandom);
        endcase
        set_ch(c, a, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               $urandom);
      end else if (pend[c] && $urandom_range(0, 40) == 0) begin
        req[c] = 1'b0;
        pend[c] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h1234] = 8'hAA;
    mem[16'h1235] = 8'hBB;
    rst_x = 1'b1;
    #1 rst_x = 1'b0;
    #2 reset_checks("rst_init");
    model_reset();
    @(negedge clk);
    rst_x = 1'b1;

    // single read on ch1
    clear_trace();
    set_ch(1, 16'h1234, 1, 1'b0, 1'b0, 32'h0);
    run_done("rd1", 40, 0);
    chk_trace("rd1_ab", '{16'h1234, 16'h1234, 16'h1235, 16'h1235});
    chk("rd1_gnt", (g_val.size() > 0) ? g_val[0] : 3'b0, 3'b010);
    chk("rd1_done", d_val[0], 3'b010);
    chk("rd1_rdata", d_rdata, 32'h0000BBAA);

    // page wrap then linear carry
    clear_trace();
    set_ch(0, 16'h01FF, 2, 1'b0, 1'b1, 32'h0);
    run_done("wrap1", 40, 0);
    chk_trace("wrap1_ab", '{16'h01FF, 16'h01FF, 16'h0100, 16'h0100,
                            16'h0101, 16'h0101});
    clear_trace();
    set_ch(0, 16'h01FF, 2, 1'b0, 1'b0, 32'h0);
    run_done("wrap0", 40, 0);
    chk_trace("wrap0_ab", '{16'h01FF, 16'h01FF, 16'h0200, 16'h0200,
                            16'h0201, 16'h0201});

    // stalled write across the 0xFFFF boundary
    clear_trace();
    set_ch(2, 16'hFFFF, 1, 1'b1, 1'b0, 32'h00005566);
    run_done("stall", 40, 3);
    chk_trace("stall_ab", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                            16'h0000, 16'h0000});
    for (int i = 0; i < q_db.size(); i++) begin
      chk("stall_db", q_db[i], (i < 4) ? 8'h66 : 8'h55);
      chk("stall_rw", q_rw[i], 1'b0);
    end
    chk("stall_done", d_val[0], 3'b100);

    // round robin with all requests held
    do_reset_mid();
    clear_trace();
    auto_drop = 1'b0;
    for (int c = 0; c < NCH; c++) set_ch(c, 16'(c * 16), 0, 1'b0, 1'b0, 0);
    i_rdy = 1'b1;
    for (int n = 0; n < 14; n++) step();
    chk("rr_count", g_val.size() >= 4, 1'b1);
    if (g_val.size() >= 4) begin
      chk("rr_g0", g_val[0], 3'b001);
      chk("rr_g1", g_val[1], 3'b010);
      chk("rr_g2", g_val[2], 3'b100);
      chk("rr_g3", g_val[3], 3'b001);
      for (int i = 1; i < 4; i++) chk("rr_gap", g_cyc[i] - g_cyc[i-1], 4);
    end
    auto_drop = 1'b1;
    req = '0; pend = '0;
    for (int n = 0; n < 4; n++) step();

    // reset during byte 1 of a 4-byte read, rr left pointing at ch2
    do_reset_mid();
    clear_trace();
    set_ch(1, 16'h4000, 3, 1'b0, 1'b0, 0);
    for (int n = 0; n < 20 && !(m_phase == 1 && m_k == 1); n++) step();
    chk("mid_reach", m_phase == 1 && m_k == 1, 1'b1);
    step();
    do_reset_mid();
    for (int n = 0; n < 3; n++) step();
    chk("mid_nodone", d_val.size(), 0);
    clear_trace();
    set_ch(1, 16'h5000, 0, 1'b0, 1'b0, 0);
    set_ch(2, 16'h6000, 0, 1'b0, 1'b0, 0);
    run_done("mid_next", 40, 0);
    chk("mid_next_gnt", (g_val.size() > 0) ? g_val[0] : 3'b0, 3'b010);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      drive_random();
      step();
      if ($urandom_range(0, 600) == 0) do_reset_mid();
    end
    req = '0; pend = '0; i_rdy = 1'b1;
    for (int n = 0; n < 12; n++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
